// File: rtl/operand_fetch_pkg.sv
// Shared state encoding and operand-length bounds for the operand fetch latch.
package operand_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam int MIN_OPERAND_BYTES = 1;
    localparam int MAX_OPERAND_BYTES = 4;

    function automatic bit len_is_legal(input int len, input int max_bytes);
        return (len >= MIN_OPERAND_BYTES) && (len <= max_bytes);
    endfunction

    function automatic bit max_bytes_is_legal(input int max_bytes);
        return (max_bytes >= MIN_OPERAND_BYTES) && (max_bytes <= MAX_OPERAND_BYTES);
    endfunction

endpackage

// File: rtl/operand_index_adder.sv
// Indexed effective address: zero-page wrap for one-byte operands, full-width add
// with byte-0 carry detection for multi-byte operands.
module operand_index_adder
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 2,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic [MAX_BYTES*DATA_W-1:0] operand,
    input  logic [CNT_W-1:0]            len_q,
    input  logic [DATA_W-1:0]           idx,
    input  logic                        idx_en,
    output logic [MAX_BYTES*DATA_W-1:0] ea,
    output logic                        page_cross
);

    localparam int OPW = MAX_BYTES * DATA_W;

    logic [DATA_W:0] low_sum;
    logic [OPW-1:0]  full_sum;
    logic [OPW-1:0]  page0_ea;

    assign low_sum = {1'b0, operand[DATA_W-1:0]} + {1'b0, idx};

    generate
        if (MAX_BYTES > 1) begin : g_multi
            assign full_sum = operand + {{(OPW-DATA_W){1'b0}}, idx};
            assign page0_ea = {{(OPW-DATA_W){1'b0}}, low_sum[DATA_W-1:0]};
        end else begin : g_single
            assign full_sum = low_sum[DATA_W-1:0];
            assign page0_ea = low_sum[DATA_W-1:0];
        end
    endgenerate

    // len_q of 0 only occurs in IDLE with a zeroed operand, so pass it through.
    always_comb begin
        ea         = operand;
        page_cross = 1'b0;
        if (idx_en) begin
            if (32'(len_q) == 32'd1) begin
                ea = page0_ea;
            end else if (32'(len_q) >= 32'd2) begin
                ea         = full_sum;
                page_cross = low_sum[DATA_W];
            end
        end
    end

endmodule

// File: rtl/operand_fetch_latch.sv
// Byte-count operand assembler: captures len little-endian bytes from the data bus
// after a start, then holds the operand valid and feeds the indexed address adder.
module operand_fetch_latch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 2,
    localparam int CNT_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        resb,
    input  logic                        start,
    input  logic [CNT_W-1:0]            len,
    input  logic                        load,
    input  logic [DATA_W-1:0]           db_in,
    input  logic                        clear,
    input  logic [DATA_W-1:0]           idx,
    input  logic                        idx_en,
    output logic                        busy,
    output logic                        valid,
    output logic                        done,
    output logic                        err,
    output logic [CNT_W-1:0]            byte_idx,
    output logic [MAX_BYTES*DATA_W-1:0] operand,
    output logic [DATA_W-1:0]           db_out,
    output logic [MAX_BYTES*DATA_W-1:0] ea,
    output logic                        page_cross
);

    generate
        if (!max_bytes_is_legal(MAX_BYTES)) begin : g_bad_max_bytes
            $error("operand_fetch_latch: MAX_BYTES out of range");
        end
    endgenerate

    fetch_state_t            state_reg;
    logic [CNT_W-1:0]        byte_idx_reg;
    logic [CNT_W-1:0]        len_q_reg;
    logic                    valid_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic                    busy_reg;
    logic [DATA_W-1:0]       byte_reg [MAX_BYTES];

    logic start_legal;
    logic load_accept;
    logic bytes_zero;
    logic last_byte;

    // clear outranks start, and any start (legal or not) swallows a same-cycle load.
    always_comb begin
        start_legal = start && len_is_legal(32'(len), MAX_BYTES);
        load_accept = !clear && !start && load && (state_reg == FETCH);
        bytes_zero  = clear || start_legal;
        last_byte   = (byte_idx_reg == (len_q_reg - CNT_W'(1)));
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BYTES; gi++) begin : g_byte
            always_ff @(posedge clk or negedge resb) begin
                if (!resb) begin
                    byte_reg[gi] <= '0;
                end else if (bytes_zero) begin
                    byte_reg[gi] <= '0;
                end else if (load_accept && (byte_idx_reg == CNT_W'(gi))) begin
                    byte_reg[gi] <= db_in;
                end
            end
            assign operand[gi*DATA_W +: DATA_W] = byte_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            len_q_reg    <= '0;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (clear) begin
                state_reg    <= IDLE;
                byte_idx_reg <= '0;
                len_q_reg    <= '0;
                valid_reg    <= 1'b0;
                busy_reg     <= 1'b0;
            end else if (start) begin
                if (start_legal) begin
                    state_reg    <= FETCH;
                    byte_idx_reg <= '0;
                    len_q_reg    <= len;
                    valid_reg    <= 1'b0;
                    busy_reg     <= 1'b1;
                end else begin
                    err_reg <= 1'b1;
                end
            end else if (load_accept) begin
                byte_idx_reg <= byte_idx_reg + CNT_W'(1);
                if (last_byte) begin
                    state_reg <= VALID;
                    valid_reg <= 1'b1;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign valid    = valid_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign byte_idx = byte_idx_reg;
    assign db_out   = byte_reg[0];

    operand_index_adder #(
        .DATA_W    (DATA_W),
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) u_index_adder (
        .operand    (operand),
        .len_q      (len_q_reg),
        .idx        (idx),
        .idx_en     (idx_en),
        .ea         (ea),
        .page_cross (page_cross)
    );

endmodule

// File: tb/tb_operand_fetch_latch.sv
// Directed scenario bench for operand_fetch_latch with DATA_W=8, MAX_BYTES=2.
module tb_operand_fetch_latch;

    logic        clk;
    logic        resb;
    logic        start;
    logic [1:0]  len;
    logic        load;
    logic [7:0]  db_in;
    logic        clear;
    logic [7:0]  idx;
    logic        idx_en;
    logic        busy;
    logic        valid;
    logic        done;
    logic        err;
    logic [1:0]  byte_idx;
    logic [15:0] operand;
    logic [7:0]  db_out;
    logic [15:0] ea;
    logic        page_cross;

    int errors = 0;
    int checks = 0;

    operand_fetch_latch #(
        .DATA_W    (8),
        .MAX_BYTES (2)
    ) dut (
        .clk        (clk),
        .resb       (resb),
        .start      (start),
        .len        (len),
        .load       (load),
        .db_in      (db_in),
        .clear      (clear),
        .idx        (idx),
        .idx_en     (idx_en),
        .busy       (busy),
        .valid      (valid),
        .done       (done),
        .err        (err),
        .byte_idx   (byte_idx),
        .operand    (operand),
        .db_out     (db_out),
        .ea         (ea),
        .page_cross (page_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start = 1'b0; len = 2'd0; load = 1'b0; db_in = 8'h00; clear = 1'b0;
    endtask

    task automatic test_reset;
        resb = 1'b0; idx = 8'h00; idx_en = 1'b0;
        idle_inputs();
        tick(); tick();
        checks++;
        if ({busy, valid, done, err, byte_idx, operand, db_out, ea, page_cross} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b done=%b err=%b bidx=%0d op=%h db=%h ea=%h pc=%b expected all 0",
                     busy, valid, done, err, byte_idx, operand, db_out, ea, page_cross);
        end
        resb = 1'b1;
        tick();
        $display("test_reset: op=%h", operand);
    endtask

    task automatic test_capture;
        start = 1'b1; len = 2'd2;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || byte_idx !== 2'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL start_fetch: got busy=%b bidx=%0d valid=%b expected busy=1 bidx=0 valid=0", busy, byte_idx, valid);
        end
        load = 1'b1; db_in = 8'h34;
        tick();
        checks++;
        if (byte_idx !== 2'd1 || busy !== 1'b1 || done !== 1'b0 || operand !== 16'h0034) begin
            errors++;
            $display("FAIL first_byte: got bidx=%0d busy=%b done=%b op=%h expected 1 1 0 0034", byte_idx, busy, done, operand);
        end
        db_in = 8'h12;
        tick();
        load = 1'b0;
        checks++;
        if (operand !== 16'h1234 || done !== 1'b1 || valid !== 1'b1 || busy !== 1'b0 || db_out !== 8'h34 || byte_idx !== 2'd2) begin
            errors++;
            $display("FAIL capture_done: got op=%h done=%b valid=%b busy=%b db=%h bidx=%0d expected 1234 1 1 0 34 2",
                     operand, done, valid, busy, db_out, byte_idx);
        end
        load = 1'b1; db_in = 8'hFF;
        tick();
        load = 1'b0;
        checks++;
        if (done !== 1'b0 || valid !== 1'b1 || operand !== 16'h1234) begin
            errors++;
            $display("FAIL valid_hold: got done=%b valid=%b op=%h expected 0 1 1234", done, valid, operand);
        end
        $display("test_capture: op=%h", operand);
    endtask

    task automatic test_index;
        start = 1'b1; len = 2'd2;
        tick();
        start = 1'b0; load = 1'b1; db_in = 8'hF0;
        tick();
        db_in = 8'h12;
        tick();
        load = 1'b0;
        idx = 8'h20; idx_en = 1'b1;
        #1;
        checks++;
        if (ea !== 16'h1310 || page_cross !== 1'b1) begin
            errors++;
            $display("FAIL abs_idx_cross: got ea=%h pc=%b expected 1310 1", ea, page_cross);
        end
        idx = 8'h0F;
        #1;
        checks++;
        if (ea !== 16'h12FF || page_cross !== 1'b0) begin
            errors++;
            $display("FAIL abs_idx_nocross: got ea=%h pc=%b expected 12ff 0", ea, page_cross);
        end
        idx_en = 1'b0;
        #1;
        checks++;
        if (ea !== 16'h12F0 || page_cross !== 1'b0) begin
            errors++;
            $display("FAIL unindexed: got ea=%h pc=%b expected 12f0 0", ea, page_cross);
        end
        $display("test_index: op=%h", operand);
    endtask

    task automatic test_zero_page;
        start = 1'b1; len = 2'd1;
        tick();
        start = 1'b0; load = 1'b1; db_in = 8'hF0;
        tick();
        load = 1'b0;
        checks++;
        if (operand !== 16'h00F0 || done !== 1'b1 || valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zp_capture: got op=%h done=%b valid=%b busy=%b expected 00f0 1 1 0", operand, done, valid, busy);
        end
        idx = 8'h20; idx_en = 1'b1;
        #1;
        checks++;
        if (ea !== 16'h0010 || page_cross !== 1'b0) begin
            errors++;
            $display("FAIL zp_wrap: got ea=%h pc=%b expected 0010 0", ea, page_cross);
        end
        idx_en = 1'b0; idx = 8'h00;
        $display("test_zero_page: ea=%h", ea);
    endtask

    task automatic test_restart;
        int done_count;
        done_count = 0;
        start = 1'b1; len = 2'd2;
        tick();
        start = 1'b0; load = 1'b1; db_in = 8'hAA;
        tick();
        if (done === 1'b1) done_count++;
        load = 1'b0; start = 1'b1; len = 2'd2;
        tick();
        if (done === 1'b1) done_count++;
        start = 1'b0;
        checks++;
        if (operand !== 16'h0000 || byte_idx !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_zero: got op=%h bidx=%0d busy=%b expected 0000 0 1", operand, byte_idx, busy);
        end
        load = 1'b1; db_in = 8'h01;
        tick();
        if (done === 1'b1) done_count++;
        db_in = 8'h02;
        tick();
        if (done === 1'b1) done_count++;
        load = 1'b0;
        tick();
        if (done === 1'b1) done_count++;
        checks++;
        if (operand !== 16'h0201 || valid !== 1'b1 || done_count != 1) begin
            errors++;
            $display("FAIL restart_result: got op=%h valid=%b dones=%0d expected 0201 1 1", operand, valid, done_count);
        end
        $display("test_restart: op=%h dones=%0d", operand, done_count);
    endtask

    task automatic test_errors;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1; len = 2'd0;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || operand !== 16'h0000) begin
            errors++;
            $display("FAIL err_len0: got err=%b busy=%b valid=%b op=%h expected 1 0 0 0000", err, busy, valid, operand);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got err=%b expected 0", err);
        end
        start = 1'b1; len = 2'd3;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || byte_idx !== 2'd0) begin
            errors++;
            $display("FAIL err_len3: got err=%b busy=%b bidx=%0d expected 1 0 0", err, busy, byte_idx);
        end
        // Capture into VALID, then clear + legal start + load together.
        start = 1'b1; len = 2'd2;
        tick();
        start = 1'b0; load = 1'b1; db_in = 8'h66;
        tick();
        db_in = 8'h55;
        tick();
        load = 1'b0;
        clear = 1'b1; start = 1'b1; len = 2'd2; load = 1'b1; db_in = 8'h77;
        tick();
        idle_inputs();
        checks++;
        if (operand !== 16'h0000 || busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_idx !== 2'd0) begin
            errors++;
            $display("FAIL clear_priority: got op=%h busy=%b valid=%b done=%b err=%b bidx=%0d expected 0000 0 0 0 0 0",
                     operand, busy, valid, done, err, byte_idx);
        end
        $display("test_errors: op=%h", operand);
    endtask

    task automatic test_async_reset;
        start = 1'b1; len = 2'd2;
        tick();
        start = 1'b0; load = 1'b1; db_in = 8'h77;
        tick();
        load = 1'b0;
        #2;
        resb = 1'b0;
        #1;
        checks++;
        if ({busy, valid, done, err, byte_idx, operand, db_out, ea, page_cross} !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b valid=%b bidx=%0d op=%h db=%h expected all 0", busy, valid, byte_idx, operand, db_out);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", done, busy);
        end
        resb = 1'b1;
        tick();
        start = 1'b1; len = 2'd2;
        tick();
        start = 1'b0; load = 1'b1; db_in = 8'hEF;
        tick();
        db_in = 8'hBE;
        tick();
        load = 1'b0;
        checks++;
        if (operand !== 16'hBEEF || done !== 1'b1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_capture: got op=%h done=%b valid=%b expected beef 1 1", operand, done, valid);
        end
        $display("test_async_reset: op=%h", operand);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_index();
        test_zero_page();
        test_restart();
        test_errors();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
